// File: rtl/arb2_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arb2_mux_ctrl
// Description : Two-requester bursted round-robin arbiter driving a 2:1 data
//               mux, with a one-entry registered valid/ready output stage.
//               Optional macro ARB2_MUX_FIXED_PRIO_EN selects strict A priority.
// Revision    : 1.0 - initial release
// ============================================================================
module arb2_mux_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout,
  input  logic              dout_ready,
  output logic              sel
);

  logic              w_load;
  logic              w_any;
  logic              w_xfer;
  logic              w_grant;
  logic              r_dout_valid;
  logic [DATA_W-1:0] r_dout;
  logic              r_sel;

  // Output stage can take a beat when empty or draining in the same cycle.
  assign w_load = ~r_dout_valid | dout_ready;
  assign w_any  = a_valid | b_valid;
  assign w_xfer = w_load & w_any;

`ifdef ARB2_MUX_FIXED_PRIO_EN
  assign w_grant = ~a_valid;
`else
  localparam int                 c_CNT_W   = $clog2(BURST_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BURST_MAX);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic               r_last;
  logic [c_CNT_W-1:0] r_cnt;

  // Contested beats stay with the last winner until its burst saturates.
  always_comb begin
    w_grant = ~a_valid;
    if (a_valid & b_valid) begin
      w_grant = (r_cnt < c_CNT_MAX) ? r_last : ~r_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last <= 1'b1;
      r_cnt  <= c_CNT_MAX;
    end else if (w_xfer) begin
      r_last <= w_grant;
      if (w_grant == r_last) begin
        r_cnt <= (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
      end else begin
        r_cnt <= c_CNT_ONE;
      end
    end
  end
`endif

  // Readies are suppressed while reset is applied so no beat is lost.
  assign a_ready = resetn & w_load & a_valid & ~w_grant;
  assign b_ready = resetn & w_load & b_valid &  w_grant;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_sel        <= 1'b0;
    end else if (w_xfer) begin
      r_dout_valid <= 1'b1;
      r_dout       <= w_grant ? b_data : a_data;
      r_sel        <= w_grant;
    end else if (dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;
  assign sel        = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_arb2_mux_ctrl.sv
`default_nettype none
// Testbench for arb2_mux_ctrl: two instances (BURST_MAX=2 and 1) share
// stimulus; a reference model feeds per-instance scoreboards.
module tb_arb2_mux_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          a_valid, b_valid, dout_ready;
  logic [DW-1:0] a_data, b_data;

  logic [1:0]         a_ready, b_ready, dout_valid, sel;
  logic [1:0][DW-1:0] dout;

  arb2_mux_ctrl #(.DATA_W(DW), .BURST_MAX(2)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready[0]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready[0]),
    .dout_valid(dout_valid[0]), .dout(dout[0]), .dout_ready(dout_ready),
    .sel(sel[0])
  );

  arb2_mux_ctrl #(.DATA_W(DW), .BURST_MAX(1)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready[1]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready[1]),
    .dout_valid(dout_valid[1]), .dout(dout[1]), .dout_ready(dout_ready),
    .sel(sel[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state, one set per instance.
  int m_bm   [2] = '{2, 1};
  int m_last [2];
  int m_cnt  [2];
  bit m_vld  [2];
  logic [DW:0] q0[$];
  logic [DW:0] q1[$];
  bit acc_a0, acc_b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int model_grant(int k);
`ifdef ARB2_MUX_FIXED_PRIO_EN
    return a_valid ? 0 : 1;
`else
    if (a_valid && b_valid) return (m_cnt[k] < m_bm[k]) ? m_last[k] : 1 - m_last[k];
    return a_valid ? 0 : 1;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vld[k] = 1'b0; m_last[k] = 1; m_cnt[k] = m_bm[k];
    end
    q0.delete(); q1.delete();
  endtask

  // One clock cycle: check at negedge, advance model after the posedge.
  task automatic cycle();
    int g [2];
    bit xf[2];
    logic [DW:0] e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      g[k]  = model_grant(k);
      xf[k] = resetn && (!m_vld[k] || dout_ready) && (a_valid || b_valid);
      check($sformatf("a_ready%0d", k), 32'(a_ready[k]), 32'(xf[k] && g[k] == 0));
      check($sformatf("b_ready%0d", k), 32'(b_ready[k]), 32'(xf[k] && g[k] == 1));
      check($sformatf("dout_valid%0d", k), 32'(dout_valid[k]), 32'(m_vld[k]));
      if (resetn && m_vld[k] && dout_ready) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          check($sformatf("sb_empty%0d", k), 32'd1, 32'd0);
        end else begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("beat%0d", k), {23'd0, sel[k], dout[k]}, {23'd0, e});
        end
      end
      if (xf[k]) begin
        e = {g[k] == 1, (g[k] == 1) ? b_data : a_data};
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    acc_a0 = xf[0] && g[0] == 0;
    acc_b0 = xf[0] && g[0] == 1;
    @(posedge clk);
    #1;
    if (!resetn) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (xf[k]) begin
          m_vld[k] = 1'b1;
          m_cnt[k] = (g[k] == m_last[k]) ? ((m_cnt[k] + 1 > m_bm[k]) ? m_bm[k] : m_cnt[k] + 1) : 1;
          m_last[k] = g[k];
        end else if (m_vld[k] && dout_ready) begin
          m_vld[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  logic [DW-1:0] exp_seq [8] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
  logic          exp_sel [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int na, nb;
    resetn = 1'b0; a_valid = 1'b0; b_valid = 1'b0; dout_ready = 1'b0;
    a_data = '0; b_data = '0;
    @(posedge clk); #1;
    model_reset();

    // Reset while a beat is held and stalled.
    resetn = 1'b1; a_valid = 1'b1; a_data = 8'h77;
    cycle();
    cycle();
    resetn = 1'b0; b_valid = 1'b1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", 32'(dout_valid[k]), 32'd0);
      check("rst_dout",  32'(dout[k]),       32'd0);
      check("rst_sel",   32'(sel[k]),        32'd0);
    end
    resetn = 1'b1;

    // A alone.
    a_valid = 1'b1; b_valid = 1'b0; a_data = 8'h5A; dout_ready = 1'b1;
    cycle();
    check("a_only_dout", 32'(dout[0]), 32'h5A);
    check("a_only_sel",  32'(sel[0]),  32'd0);
    a_valid = 1'b0;
    cycle();

    // Continuous contention with incrementing producer data.
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; dout_ready = 1'b1; na = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      a_data = 8'(8'h10 + na);
      b_data = 8'(8'h20 + nb);
      cycle();
      if (acc_a0) na++;
      if (acc_b0) nb++;
`ifdef ARB2_MUX_FIXED_PRIO_EN
      check("fixed_dout", 32'(dout[0]), 32'(8'h10 + i));
      check("fixed_sel",  32'(sel[0]),  32'd0);
`else
      check("rr_dout", 32'(dout[0]), 32'(exp_seq[i]));
      check("rr_sel",  32'(sel[0]),  32'(exp_sel[i]));
`endif
    end

    // Stall three cycles, then simultaneous drain and load.
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_data = 8'hC0 + 8'(i); b_data = 8'hD0 + 8'(i);
      cycle();
      check("stall_dout", {23'd0, sel[0], dout[0]}, {23'd0, q0[0]});
    end
    dout_ready = 1'b1;
    cycle();
    check("no_bubble", 32'(dout_valid[0]), 32'd1);

`ifdef ARB2_MUX_FIXED_PRIO_EN
    a_valid = 1'b0;
    cycle();
    check("fixed_b_after_drop", 32'(sel[0]), 32'd1);
`endif

    // BURST_MAX=1 instance: A alone three beats, then contention.
    a_valid = 1'b0; b_valid = 1'b0;
    do_reset();
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin a_data = 8'(i); cycle(); end
    b_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = 8'h40 + 8'(i); b_data = 8'h50 + 8'(i);
      cycle();
`ifdef ARB2_MUX_FIXED_PRIO_EN
      check("bm1_sel", 32'(sel[1]), 32'd0);
`else
      check("bm1_sel", 32'(sel[1]), 32'((i % 2) == 0));
`endif
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      resetn     = ($urandom_range(0, 99) != 0);
      a_valid    = $urandom_range(0, 2) != 0;
      b_valid    = $urandom_range(0, 2) != 0;
      dout_ready = $urandom_range(0, 3) != 0;
      a_data     = 8'($urandom);
      b_data     = 8'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
